hex_scan_display: RTL and testbench

- Parametrised, time-multiplexed seven-segment display driver for N digits on a shared-segment, common-anode board.
- Latches a hex word, decimal-point mask and blink mask on a load strobe. Scans one digit at a time at a programmable rate and generates its own blink phase.
- Drives active-low segments and active-low digit enables directly to board pins. Sits between the CPU debug/IO bus and the display pins.

---
 rtl/hex_scan_display.sv | 167 ++++++++++++++++
 tb/tb_hex_scan_display.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_display.sv
// Time-multiplexed seven-segment driver for a common-anode, shared-segment board.
// Scans one digit per SCAN_DIV cycles, blinks selected digits, all pins registered.
module hex_scan_display #(
   parameter int N_DIGITS     = 8,
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] hexs,
   input  logic [N_DIGITS-1:0]   points,
   input  logic [N_DIGITS-1:0]   les,
   output logic [7:0]            seg_n,
   output logic [N_DIGITS-1:0]   an_n,
   output logic                  flash,
   output logic                  frame_done
);

   localparam int PW = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
   localparam int IW = (N_DIGITS > 1)     ? $clog2(N_DIGITS)     : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   logic [4*N_DIGITS-1:0] hex_q, hex_d;
   logic [N_DIGITS-1:0]   pt_q, pt_d;
   logic [N_DIGITS-1:0]   le_q, le_d;
   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [FW-1:0]         frame_q, frame_d;
   logic                  flash_q, flash_d;
   logic [7:0]            seg_q, seg_d;
   logic [N_DIGITS-1:0]   an_q, an_d;
   logic                  done_q, done_d;

   logic                  tick_s;
   logic                  frame_end_s;
   logic [3:0]            cur_hex_s;
   logic                  cur_pt_s;
   logic                  cur_le_s;

   // Active-low a..g pattern for one hex nibble.
   function automatic logic [6:0] dec7(input logic [3:0] v);
      logic [6:0] r;
      case (v)
         4'h0:    r = 7'b0000001;
         4'h1:    r = 7'b1001111;
         4'h2:    r = 7'b0010010;
         4'h3:    r = 7'b0000110;
         4'h4:    r = 7'b1001100;
         4'h5:    r = 7'b0100100;
         4'h6:    r = 7'b0100000;
         4'h7:    r = 7'b0001111;
         4'h8:    r = 7'b0000000;
         4'h9:    r = 7'b0000100;
         4'hA:    r = 7'b0001000;
         4'hB:    r = 7'b1100000;
         4'hC:    r = 7'b0110001;
         4'hD:    r = 7'b1000010;
         4'hE:    r = 7'b0110000;
         4'hF:    r = 7'b0111000;
         default: r = 7'b1111111;
      endcase
      return r;
   endfunction

   // Next-state logic for latch, scan counters, blink phase and pin drivers.
   always_comb begin
      tick_s      = (presc_q == PRESC_LAST);
      frame_end_s = tick_s & (idx_q == IDX_LAST);

      if (load) begin
         hex_d = hexs;
         pt_d  = points;
         le_d  = les;
      end else begin
         hex_d = hex_q;
         pt_d  = pt_q;
         le_d  = le_q;
      end

      if (tick_s) begin
         presc_d = '0;
      end else begin
         presc_d = presc_q + PW'(1);
      end

      if (tick_s) begin
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
         end else begin
            idx_d = idx_q + IW'(1);
         end
      end else begin
         idx_d = idx_q;
      end

      // Blink phase advances on whole frames only, so scan timing never depends on it.
      if (frame_end_s) begin
         if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            flash_d = ~flash_q;
         end else begin
            frame_d = frame_q + FW'(1);
            flash_d = flash_q;
         end
      end else begin
         frame_d = frame_q;
         flash_d = flash_q;
      end

      done_d = frame_end_s;

      cur_hex_s = 4'h0;
      cur_pt_s  = 1'b0;
      cur_le_s  = 1'b0;
      an_d      = '1;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            cur_hex_s = hex_q[4*i +: 4];
            cur_pt_s  = pt_q[i];
            cur_le_s  = le_q[i];
            an_d[i]   = 1'b0;
         end else begin
            an_d[i]   = 1'b1;
         end
      end

      seg_d = {dec7(cur_hex_s), ~cur_pt_s} | {8{cur_le_s & flash_q}};
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         hex_q   <= '0;
         pt_q    <= '0;
         le_q    <= '0;
         presc_q <= '0;
         idx_q   <= '0;
         frame_q <= '0;
         flash_q <= 1'b0;
         seg_q   <= 8'hFF;
         an_q    <= '1;
         done_q  <= 1'b0;
      end else begin
         hex_q   <= hex_d;
         pt_q    <= pt_d;
         le_q    <= le_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         flash_q <= flash_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
         done_q  <= done_d;
      end
   end

   assign seg_n      = seg_q;
   assign an_n       = an_q;
   assign flash      = flash_q;
   assign frame_done = done_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench: 4-digit instance (SCAN_DIV=2, BLINK_FRAMES=2) and a 1-digit
// instance (SCAN_DIV=1, BLINK_FRAMES=1) sharing clock and reset.
module tb_hex_scan_display;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] hexs = 16'h0000;
   logic [3:0]  points = 4'h0;
   logic [3:0]  les = 4'h0;
   logic [7:0]  seg_n;
   logic [3:0]  an_n;
   logic        flash;
   logic        frame_done;

   logic        load1 = 1'b0;
   logic [3:0]  hexs1 = 4'h0;
   logic [0:0]  points1 = 1'b0;
   logic [0:0]  les1 = 1'b0;
   logic [7:0]  seg1_n;
   logic [0:0]  an1_n;
   logic        flash1;
   logic        frame_done1;

   int n_pass  = 0;
   int n_total = 0;
   int k       = 0;

   always #5 clk = ~clk;

   hex_scan_display #(.N_DIGITS(4), .SCAN_DIV(2), .BLINK_FRAMES(2)) u_dut (
      .clk(clk), .rst(rst), .load(load), .hexs(hexs), .points(points), .les(les),
      .seg_n(seg_n), .an_n(an_n), .flash(flash), .frame_done(frame_done)
   );

   hex_scan_display #(.N_DIGITS(1), .SCAN_DIV(1), .BLINK_FRAMES(1)) u_one (
      .clk(clk), .rst(rst), .load(load1), .hexs(hexs1), .points(points1), .les(les1),
      .seg_n(seg1_n), .an_n(an1_n), .flash(flash1), .frame_done(frame_done1)
   );

   function automatic logic [6:0] seg7_ref(input logic [3:0] v);
      logic [6:0] t [16];
      t = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
            7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
      return t[v];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
      k = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      load = 1'b1;
      hexs = 16'h1234;
      step();
      step();
      load = 1'b0;
      n_total++; if (seg_n !== 8'hFF) $display("FAIL reset_seg got %h want ff", seg_n); else n_pass++;
      n_total++; if (an_n !== 4'hF) $display("FAIL reset_an got %b want 1111", an_n); else n_pass++;
      n_total++; if (flash !== 1'b0) $display("FAIL reset_flash got %b want 0", flash); else n_pass++;
      n_total++; if (frame_done !== 1'b0) $display("FAIL reset_done got %b want 0", frame_done); else n_pass++;
      n_total++; if (an1_n !== 1'b1) $display("FAIL reset_an1 got %b want 1", an1_n); else n_pass++;
      rst = 1'b0;
      k = 0;
      step();
      n_total++; if (seg_n !== 8'h03) $display("FAIL reset_loadblocked got %h want 03", seg_n); else n_pass++;
   endtask

   task automatic test_scan();
      int d;
      do_reset();
      for (int i = 0; i < 24; i++) begin
         step();
         d = ((k - 1) / 2) % 4;
         n_total++; if (an_n !== ~(4'b0001 << d)) $display("FAIL scan_an k=%0d got %b want %b", k, an_n, ~(4'b0001 << d)); else n_pass++;
         n_total++; if (seg_n !== 8'h03) $display("FAIL scan_seg k=%0d got %h want 03", k, seg_n); else n_pass++;
         n_total++; if (frame_done !== (k % 8 == 0)) $display("FAIL scan_done k=%0d got %b want %b", k, frame_done, (k % 8 == 0)); else n_pass++;
      end
   endtask

   task automatic test_hex();
      logic [7:0] exp_tab [4];
      int d;
      exp_tab = '{8'h00, 8'h11, 8'h9F, 8'h71};
      do_reset();
      hexs = 16'hF1A8; points = 4'b0001; les = 4'b0000; load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step();
         d = ((k - 1) / 2) % 4;
         n_total++; if (an_n !== ~(4'b0001 << d)) $display("FAIL hex_an k=%0d got %b", k, an_n); else n_pass++;
         n_total++; if (seg_n !== exp_tab[d]) $display("FAIL hex_seg k=%0d got %h want %h", k, seg_n, exp_tab[d]); else n_pass++;
      end
   endtask

   task automatic test_blink();
      logic [7:0] exp_tab [4];
      logic [7:0] e;
      int d;
      exp_tab = '{8'h00, 8'h11, 8'h9F, 8'h71};
      do_reset();
      hexs = 16'hF1A8; points = 4'b0001; les = 4'b0010; load = 1'b1;
      step();
      load = 1'b0;
      n_total++; if (flash !== 1'b0) $display("FAIL blink_flash k=%0d got %b want 0", k, flash); else n_pass++;
      for (int i = 0; i < 64; i++) begin
         step();
         d = ((k - 1) / 2) % 4;
         e = exp_tab[d];
         if (d == 1 && ((k - 1) / 16) % 2 == 1) e = 8'hFF;
         n_total++; if (flash !== ((k / 16) % 2 == 1)) $display("FAIL blink_flash k=%0d got %b", k, flash); else n_pass++;
         n_total++; if (seg_n !== e) $display("FAIL blink_seg k=%0d got %h want %h", k, seg_n, e); else n_pass++;
         n_total++; if (an_n !== ~(4'b0001 << d)) $display("FAIL blink_an k=%0d got %b", k, an_n); else n_pass++;
      end
      les = 4'b0000;
   endtask

   task automatic test_back_to_back();
      logic [15:0] hist [0:63];
      logic [3:0]  nib;
      logic [7:0]  e;
      int d;
      do_reset();
      points = 4'b0000; les = 4'b0000;
      for (int i = 0; i < 40; i++) begin
         hexs = 16'($urandom);
         hist[k + 1] = hexs;
         load = 1'b1;
         step();
         if (k >= 2) begin
            d = ((k - 1) / 2) % 4;
            nib = hist[k - 1][4*d +: 4];
            e = {seg7_ref(nib), 1'b1};
            n_total++; if (seg_n !== e) $display("FAIL b2b_seg k=%0d got %h want %h", k, seg_n, e); else n_pass++;
            n_total++; if (an_n !== ~(4'b0001 << d)) $display("FAIL b2b_an k=%0d got %b", k, an_n); else n_pass++;
         end
      end
      load = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      hexs = 16'h5555; points = 4'b0000; les = 4'b0100; load = 1'b1;
      step();
      load = 1'b0;
      while (k < 20) step();
      n_total++; if (flash !== 1'b1) $display("FAIL mid_preflash got %b want 1", flash); else n_pass++;
      step();
      n_total++; if (an_n !== 4'b1011) $display("FAIL mid_prean got %b want 1011", an_n); else n_pass++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_total++; if (seg_n !== 8'hFF) $display("FAIL mid_seg got %h want ff", seg_n); else n_pass++;
      n_total++; if (an_n !== 4'hF) $display("FAIL mid_an got %b want 1111", an_n); else n_pass++;
      n_total++; if (flash !== 1'b0) $display("FAIL mid_flash got %b want 0", flash); else n_pass++;
      step();
      n_total++; if (an_n !== 4'b1110) $display("FAIL mid_an0 got %b want 1110", an_n); else n_pass++;
      n_total++; if (seg_n !== 8'h03) $display("FAIL mid_seg0 got %h want 03", seg_n); else n_pass++;
      step();
      n_total++; if (an_n !== 4'b1110) $display("FAIL mid_an0b got %b want 1110", an_n); else n_pass++;
      step();
      n_total++; if (an_n !== 4'b1101) $display("FAIL mid_an1 got %b want 1101", an_n); else n_pass++;
      les = 4'b0000;
   endtask

   task automatic test_single();
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step();
         n_total++; if (an1_n !== 1'b0) $display("FAIL one_an k=%0d got %b want 0", k, an1_n); else n_pass++;
         n_total++; if (frame_done1 !== 1'b1) $display("FAIL one_done k=%0d got %b want 1", k, frame_done1); else n_pass++;
         n_total++; if (flash1 !== (k % 2 == 1)) $display("FAIL one_flash k=%0d got %b want %b", k, flash1, (k % 2 == 1)); else n_pass++;
         n_total++; if (seg1_n !== 8'h03) $display("FAIL one_seg k=%0d got %h want 03", k, seg1_n); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_hex();
      test_blink();
      test_back_to_back();
      test_reset_mid();
      test_single();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
